rf_dbg_access_ctrl: RTL and testbench
=====================================

# rf_dbg_access_ctrl

Sequences debug-module register accesses onto the integer register file and shares the register file's single write port between the pipeline writeback stage and the debug module. It sits between the writeback stage, the debug module and the register file. Pipeline writeback always has priority. A starvation counter raises a stall request to the pipeline if a debug write waits too long.

## Interface
Parameters:
- XLEN, 32, data width.
- RF_AWIDTH, 5, register address width.
- STARVE_LIMIT, 4, consecutive blocked cycles before `stall_o` asserts (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dbg_halted_i  in  1  core is halted in debug mode.
- dbg_req_valid_i  in  1  debug request valid.
- dbg_req_ready_o  out  1  controller can accept a request.
- dbg_req_we_i  in  1  1 = write, 0 = read.
- dbg_req_addr_i  in  RF_AWIDTH  register index.
- dbg_req_wdata_i  in  XLEN  write data.
- dbg_rsp_valid_o  out  1  response valid.
- dbg_rsp_ready_i  in  1  debug module accepts the response.
- dbg_rsp_rdata_o  out  XLEN  read data; 0 for writes and errors.
- dbg_rsp_err_o  out  1  access refused because the core was not halted.
- wb_wr_req_i  in  1  pipeline writeback write request.
- wb_rd_addr_i  in  RF_AWIDTH  pipeline rd address.
- wb_rd_data_i  in  XLEN  pipeline rd data.
- rf_wr_req_o  out  1  write request to the register file.
- rf_rd_addr_o  out  RF_AWIDTH  write address to the register file.
- rf_rd_data_o  out  XLEN  write data to the register file.
- rf_rs1_sel_o  out  1  controller owns the rs1 read port this cycle.
- rf_rs1_addr_o  out  RF_AWIDTH  rs1 read address when `rf_rs1_sel_o` = 1.
- rf_rs1_data_i  in  XLEN  rs1 asynchronous read data.
- stall_o  out  1  request to the pipeline to freeze writeback.

## Operation
FSM states: IDLE, RD, WR, RSP.
- **IDLE**
  - `dbg_req_ready_o` = 1 only in this state.
  - A request is accepted on `valid & ready`; address, write data and type are latched.
  - If `dbg_halted_i` = 0 at accept, set err = 1 and go to RSP.
  - Otherwise go to RD for a read, or WR for a write.
- **RD**
  - Drives `rf_rs1_sel_o` = 1 and `rf_rs1_addr_o` = latched address.
  - Captures `rf_rs1_data_i` into the response register at the end of the cycle, then goes to RSP.
  - Address 0 returns 0.
- **WR**
  - If `wb_wr_req_i` = 1, the pipeline owns the write port. The starve counter increments and saturates at STARVE_LIMIT.
  - If `wb_wr_req_i` = 0, the controller drives `rf_wr_req_o` = 1 with the latched address and data for exactly this cycle. It then clears the counter and goes to RSP.
  - A write to address 0 is issued normally; the register file discards it; err = 0.
- **RSP**
  - `dbg_rsp_valid_o` = 1, with rdata and err held stable.
  - On `dbg_rsp_ready_i` = 1, go to IDLE.
- **Write port mux (combinational)**
  - If `wb_wr_req_i` = 1, `rf_wr_*` = `wb_*` pass-through.
  - Else, in a granted WR cycle, `rf_wr_*` = latched debug values.
  - Else `rf_wr_req_o` = 0 and address/data = 0.
- **Stall:** `stall_o` = 1 while in WR and counter == STARVE_LIMIT. It deasserts in the cycle after the debug write issues.
- **Halt changes:** `dbg_halted_i` is sampled only at accept. Deassertion mid-operation does not abort the access.

## Timing
- Reset values:
  - State = IDLE, counter = 0.
  - `dbg_req_ready_o` = 1.
  - All other outputs = 0.
  - An in-flight access or response is dropped.
- Read: accept at edge N, RD during cycle N→N+1, `dbg_rsp_valid_o` high after edge N+1. Latency 2 edges to response.
- Write with no contention: accept at edge N, `rf_wr_req_o` high for cycle N→N+1. The register file commits on the falling edge inside that cycle. Response is valid after edge N+1.
- Write blocked k cycles: the write issues k cycles later. `stall_o` rises after STARVE_LIMIT blocked cycles.
- Error response: valid after edge N+1; no register file access occurs.
- Read-after-write: a debug read accepted right after a debug write response returns the new value, because the falling-edge commit precedes the RD capture.
- Back-to-back:
  - A response accepted at edge M returns to IDLE; `dbg_req_ready_o` = 1 after edge M.
  - A new request is accepted no earlier than edge M+1.
  - Throughput is at most one access per 3 cycles.

## Test plan
- Halted; write x5 = 0xDEADBEEF with `wb_wr_req_i` = 0 -> `rf_wr_req_o` for 1 cycle, addr 5, data 0xDEADBEEF; response err = 0, rdata = 0; a following read of x5 returns 0xDEADBEEF.
- Not halted; read x3 -> response err = 1 after 2 edges, rdata = 0; `rf_rs1_sel_o` never asserts.
- Halted; debug write to x7 while `wb_wr_req_i` = 1 for 6 cycles (wb addr 9, data 0x11), STARVE_LIMIT = 4 -> wb values pass through unchanged; `stall_o` rises after 4 blocked cycles; debug write issues on the first idle cycle; `stall_o` then drops.
- Read x0 -> rdata = 0. Write x0 = 0x1234 -> write issued, err = 0; a subsequent read of x0 = 0.
- Hold `dbg_rsp_ready_i` = 0 for 5 cycles -> response stays valid and stable, `dbg_req_ready_o` = 0; ready goes high after the handshake.
- Assert `rst` asynchronously while in WR and blocked -> state returns to IDLE immediately, `stall_o` = 0 and `rf_wr_req_o` follows `wb_wr_req_i` only; no response is produced.

Source files
------------

// File: rtl/rf_dbg_access_ctrl_if.sv
// Debug request/response, writeback and register-file port bundle
// for the debug register access controller.
interface rf_dbg_access_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int RF_AWIDTH = 5
);
  logic                 dbg_halted_i;
  logic                 dbg_req_valid_i;
  logic                 dbg_req_ready_o;
  logic                 dbg_req_we_i;
  logic [RF_AWIDTH-1:0] dbg_req_addr_i;
  logic [XLEN-1:0]      dbg_req_wdata_i;
  logic                 dbg_rsp_valid_o;
  logic                 dbg_rsp_ready_i;
  logic [XLEN-1:0]      dbg_rsp_rdata_o;
  logic                 dbg_rsp_err_o;
  logic                 wb_wr_req_i;
  logic [RF_AWIDTH-1:0] wb_rd_addr_i;
  logic [XLEN-1:0]      wb_rd_data_i;
  logic                 rf_wr_req_o;
  logic [RF_AWIDTH-1:0] rf_rd_addr_o;
  logic [XLEN-1:0]      rf_rd_data_o;
  logic                 rf_rs1_sel_o;
  logic [RF_AWIDTH-1:0] rf_rs1_addr_o;
  logic [XLEN-1:0]      rf_rs1_data_i;
  logic                 stall_o;

  modport slave (
    input  dbg_halted_i, dbg_req_valid_i, dbg_req_we_i,
    input  dbg_req_addr_i, dbg_req_wdata_i, dbg_rsp_ready_i,
    input  wb_wr_req_i, wb_rd_addr_i, wb_rd_data_i,
    input  rf_rs1_data_i,
    output dbg_req_ready_o, dbg_rsp_valid_o,
    output dbg_rsp_rdata_o, dbg_rsp_err_o,
    output rf_wr_req_o, rf_rd_addr_o, rf_rd_data_o,
    output rf_rs1_sel_o, rf_rs1_addr_o, stall_o
  );

  modport master (
    output dbg_halted_i, dbg_req_valid_i, dbg_req_we_i,
    output dbg_req_addr_i, dbg_req_wdata_i, dbg_rsp_ready_i,
    output wb_wr_req_i, wb_rd_addr_i, wb_rd_data_i,
    output rf_rs1_data_i,
    input  dbg_req_ready_o, dbg_rsp_valid_o,
    input  dbg_rsp_rdata_o, dbg_rsp_err_o,
    input  rf_wr_req_o, rf_rd_addr_o, rf_rd_data_o,
    input  rf_rs1_sel_o, rf_rs1_addr_o, stall_o
  );
endinterface

// File: rtl/rf_dbg_access_ctrl.sv
// Debug-module register file access sequencer; shares the single
// write port with writeback, which always wins.
module rf_dbg_access_ctrl #(
  parameter int XLEN         = 32,
  parameter int RF_AWIDTH    = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  rf_dbg_access_ctrl_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RSP
  } state_t;

  state_t               r_state;
  logic [RF_AWIDTH-1:0] r_addr;
  logic [XLEN-1:0]      r_wdata;
  logic [XLEN-1:0]      r_rdata;
  logic                 r_err;
  logic [CW-1:0]        r_cnt;

  logic w_accept;
  logic w_grant;
  logic w_starved;

  assign w_accept  = bus.dbg_req_valid_i && (r_state == S_IDLE);
  assign w_grant   = (r_state == S_WR) && !bus.wb_wr_req_i;
  assign w_starved = (r_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.dbg_req_addr_i;
            r_wdata <= bus.dbg_req_wdata_i;
            r_rdata <= '0;
            r_err   <= !bus.dbg_halted_i;
            r_cnt   <= '0;
            if (!bus.dbg_halted_i)
              r_state <= S_RSP;
            else if (bus.dbg_req_we_i)
              r_state <= S_WR;
            else
              r_state <= S_RD;
          end
        end
        S_RD: begin
          r_rdata <= (r_addr == '0) ? '0 : bus.rf_rs1_data_i;
          r_state <= S_RSP;
        end
        S_WR: begin
          if (bus.wb_wr_req_i) begin
            if (!w_starved)
              r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt   <= '0;
            r_state <= S_RSP;
          end
        end
        S_RSP: begin
          if (bus.dbg_rsp_ready_i)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dbg_req_ready_o = (r_state == S_IDLE);
  assign bus.dbg_rsp_valid_o = (r_state == S_RSP);
  assign bus.dbg_rsp_rdata_o = (r_state == S_RSP) ? r_rdata : '0;
  assign bus.dbg_rsp_err_o   = (r_state == S_RSP) && r_err;
  assign bus.rf_rs1_sel_o    = (r_state == S_RD);
  assign bus.rf_rs1_addr_o   = (r_state == S_RD) ? r_addr : '0;
  assign bus.stall_o         = (r_state == S_WR) && w_starved;

  always_comb begin
    bus.rf_wr_req_o  = 1'b0;
    bus.rf_rd_addr_o = '0;
    bus.rf_rd_data_o = '0;
    if (bus.wb_wr_req_i) begin
      bus.rf_wr_req_o  = 1'b1;
      bus.rf_rd_addr_o = bus.wb_rd_addr_i;
      bus.rf_rd_data_o = bus.wb_rd_data_i;
    end else if (w_grant) begin
      bus.rf_wr_req_o  = 1'b1;
      bus.rf_rd_addr_o = r_addr;
      bus.rf_rd_data_o = r_wdata;
    end
  end
endmodule

// File: tb/tb_rf_dbg_access_ctrl.sv
// Vector-table bench for rf_dbg_access_ctrl with a falling-edge
// register file model behind it.
module tb_rf_dbg_access_ctrl;
  localparam logic [31:0] D = 32'hDEADBEEF;

  logic clk;
  logic rst;

  rf_dbg_access_ctrl_if #(.XLEN(32), .RF_AWIDTH(5)) bus ();

  rf_dbg_access_ctrl #(
    .XLEN(32), .RF_AWIDTH(5), .STARVE_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x0 reads back all-ones so the controller's own zeroing is visible
  logic [31:0] rf [32] = '{default: 32'h0};
  always @(negedge clk)
    if (bus.rf_wr_req_o && bus.rf_rd_addr_o != 5'd0)
      rf[bus.rf_rd_addr_o] <= bus.rf_rd_data_o;
  assign bus.rf_rs1_data_i = (bus.rf_rs1_addr_o == 5'd0) ?
                             32'hFFFF_FFFF : rf[bus.rf_rs1_addr_o];

  typedef struct {
    logic rst, hl, rv, we;
    logic [4:0] a;
    logic [31:0] wd;
    logic rr, wb;
    logic [4:0] wba;
    logic [31:0] wbd;
    logic [79:0] exp;
  } vec_t;

  vec_t vq[$];
  int n_vec;
  int n_bad;

  function automatic void add(
    input logic r, hl, rv, we, input logic [4:0] a,
    input logic [31:0] wd, input logic rr, wb,
    input logic [4:0] wba, input logic [31:0] wbd,
    input logic e_rdy, e_rv, input logic [31:0] e_rd,
    input logic e_err, e_wr, input logic [4:0] e_wa,
    input logic [31:0] e_wd, input logic e_sel,
    input logic [4:0] e_sa, input logic e_st);
    vec_t v;
    v.rst = r; v.hl = hl; v.rv = rv; v.we = we;
    v.a = a; v.wd = wd; v.rr = rr; v.wb = wb;
    v.wba = wba; v.wbd = wbd;
    v.exp = {e_rdy, e_rv, e_rd, e_err, e_wr,
             e_wa, e_wd, e_sel, e_sa, e_st};
    vq.push_back(v);
  endfunction

  function automatic logic [79:0] act();
    return {bus.dbg_req_ready_o, bus.dbg_rsp_valid_o,
            bus.dbg_rsp_rdata_o, bus.dbg_rsp_err_o,
            bus.rf_wr_req_o, bus.rf_rd_addr_o,
            bus.rf_rd_data_o, bus.rf_rs1_sel_o,
            bus.rf_rs1_addr_o, bus.stall_o};
  endfunction

  task automatic chk32(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                 = v.rst;
    bus.dbg_halted_i    = v.hl;
    bus.dbg_req_valid_i = v.rv;
    bus.dbg_req_we_i    = v.we;
    bus.dbg_req_addr_i  = v.a;
    bus.dbg_req_wdata_i = v.wd;
    bus.dbg_rsp_ready_i = v.rr;
    bus.wb_wr_req_i     = v.wb;
    bus.wb_rd_addr_i    = v.wba;
    bus.wb_rd_data_i    = v.wbd;
  endtask

  int t1, t2, rdy3;
  logic [31:0] d1, d2;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.dbg_halted_i = 0; bus.dbg_req_valid_i = 0;
    bus.dbg_req_we_i = 0; bus.dbg_req_addr_i = 0;
    bus.dbg_req_wdata_i = 0; bus.dbg_rsp_ready_i = 0;
    bus.wb_wr_req_i = 0; bus.wb_rd_addr_i = 0;
    bus.wb_rd_data_i = 0;

    // reset state
    add(0,0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    // write x5, then read it back
    add(0,1,1,1,5,D, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0,1,5,D,0,0,0);
    add(0,1,0,0,0,0, 1,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    add(0,1,1,0,5,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,1,5,0);
    add(0,1,0,0,0,0, 1,0,0,0, 0,1,D,0,0,0,0,0,0,0);
    // not halted: error response, no RF access
    add(0,0,1,0,3,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,0,0,0, 0,1,0,1,0,0,0,0,0,0);
    // write x7 blocked 6 cycles by writeback
    add(0,1,1,1,7,32'h77, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 6; k++)
      add(0,1,0,0,0,0, 0,1,9,32'h11,
          0,0,0,0,1,9,32'h11,0,0, k >= 4);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0,1,7,32'h77,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    // read x0, write x0, read x0
    add(0,1,1,0,0,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,1,0,0);
    add(0,1,0,0,0,0, 1,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    add(0,1,1,1,0,32'h1234, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0,1,0,32'h1234,0,0,0);
    add(0,1,0,0,0,0, 1,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    add(0,1,1,0,0,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,1,0,0);
    add(0,1,0,0,0,0, 1,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    // read x9 with response held 5 cycles, halt dropped mid-op
    add(0,1,1,0,9,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,1,9,0);
    for (int k = 0; k < 5; k++)
      add(0,0,0,0,0,0, 0,0,0,0, 0,1,32'h11,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,0,0,0, 0,1,32'h11,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    // async reset while blocked in WR
    add(0,1,1,1,4,32'h44, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 5; k++)
      add(0,1,0,0,0,0, 0,1,2,32'h22,
          0,0,0,0,1,2,32'h22,0,0, k >= 4);
    add(1,1,0,0,0,0, 1,1,2,32'h22, 1,0,0,0,1,2,32'h22,0,0,0);
    add(0,1,0,0,0,0, 1,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,1,1,0,4,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,1,4,0);
    add(0,1,0,0,0,0, 1,0,0,0, 0,1,0,0,0,0,0,0,0,0);

    repeat (2) @(posedge clk);
    foreach (vq[i]) begin
      @(posedge clk);
      #1 drive(vq[i]);
      #1;
      n_vec++;
      if (act() !== vq[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d act=%h exp=%h", i, act(), vq[i].exp);
      end
    end

    // back-to-back reads of x7 with request held valid
    @(posedge clk);
    #1;
    bus.dbg_halted_i = 1; bus.dbg_req_valid_i = 1;
    bus.dbg_req_we_i = 0; bus.dbg_req_addr_i = 7;
    bus.dbg_rsp_ready_i = 1; bus.wb_wr_req_i = 0;
    t1 = -1; t2 = -1; rdy3 = 0; d1 = 0; d2 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) rdy3 = bus.dbg_req_ready_o;
      if (bus.dbg_rsp_valid_o) begin
        if (t1 < 0) begin
          t1 = i; d1 = bus.dbg_rsp_rdata_o;
        end else if (t2 < 0) begin
          t2 = i; d2 = bus.dbg_rsp_rdata_o;
        end
      end
    end
    bus.dbg_req_valid_i = 0;
    chk32("b2b_lat1", t1, 2);
    chk32("b2b_lat2", t2, 5);
    chk32("b2b_d1", d1, 32'h77);
    chk32("b2b_d2", d2, 32'h77);
    chk32("b2b_ready", rdy3, 1);

    // register file contents left behind
    chk32("rf_x5", rf[5], D);
    chk32("rf_x7", rf[7], 32'h77);
    chk32("rf_x9", rf[9], 32'h11);
    chk32("rf_x2", rf[2], 32'h22);
    chk32("rf_x4_dropped", rf[4], 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
